// File: rtl/vga_mem_arbiter.sv
// -----------------------------------------------------------------------------
// vga_mem_arbiter
//
// Single-port framebuffer RAM arbiter shared by the VGA pixel fetcher and the
// AXI-Lite slave FSM. AXI write/read strobes are captured into one pending
// slot each and are scheduled around real-time pixel fetches. A bounded-wait
// counter forces an AXI grant after MAX_WAIT denied cycles so a continuous
// pixel stream cannot starve the bus.
//
// Ports
//   clk, arst_n          clock (posedge) / asynchronous active-low reset
//   axil_write_en_i      one-cycle write strobe; addr/data sampled with it
//   axil_addr_write_i    write word address
//   axil_data_i          write data
//   axil_read_en_i       one-cycle read strobe; addr sampled with it
//   axil_addr_read_i     read word address
//   axil_rdata_o         registered read data, held until the next AXI read
//   axil_rvalid_o        one-cycle pulse, axil_rdata_o valid
//   axil_busy_o          any AXI request pending
//   axil_overflow_o      sticky: strobe arrived while same-kind request pending
//   pix_req_i/addr_i     pixel fetch request (level) and address
//   pix_gnt_o            combinational pixel grant for this cycle
//   pix_rdata_o          pass-through of mem_rdata_i
//   pix_rvalid_o         pixel data valid (cycle after pix_gnt_o)
//   mem_en_o/we_o        RAM enable / write enable (combinational)
//   mem_addr_o/wdata_o   RAM address / write data (combinational)
//   mem_rdata_i          RAM read data, one cycle after the read command
// -----------------------------------------------------------------------------
module vga_mem_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 8     // legal range 1..255
) (
   input  logic              clk,
   input  logic              arst_n,

   input  logic              axil_write_en_i,
   input  logic [ADDR_W-1:0] axil_addr_write_i,
   input  logic [DATA_W-1:0] axil_data_i,
   input  logic              axil_read_en_i,
   input  logic [ADDR_W-1:0] axil_addr_read_i,
   output logic [DATA_W-1:0] axil_rdata_o,
   output logic              axil_rvalid_o,
   output logic              axil_busy_o,
   output logic              axil_overflow_o,

   input  logic              pix_req_i,
   input  logic [ADDR_W-1:0] pix_addr_i,
   output logic              pix_gnt_o,
   output logic [DATA_W-1:0] pix_rdata_o,
   output logic              pix_rvalid_o,

   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   // Who drives the RAM port in the current cycle.
   typedef enum logic [1:0] {
      OwnIdle,
      OwnPix,
      OwnWr,
      OwnRd
   } owner_t;

   // Which requester the read issued last cycle belongs to.
   typedef enum logic [1:0] {
      StNone,
      StPix,
      StAxr
   } tag_t;

   // Pending AXI requests
   logic              r_wr_pend;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_rd_pend;
   logic [ADDR_W-1:0] r_rd_addr;

   // Arbitration / return path state
   logic [7:0]        r_wait_cnt;
   tag_t              r_tag;
   logic [DATA_W-1:0] r_axil_rdata;
   logic              r_axil_rvalid;
   logic              r_overflow;

   owner_t            w_owner;
   logic              w_any_pend;
   logic              w_forced;
   logic              w_wr_drop;
   logic              w_rd_drop;

   assign w_any_pend = r_wr_pend | r_rd_pend;
   assign w_forced   = (r_wait_cnt == MAX_WAIT_C) && w_any_pend;

   // ---------------------------------------------------------------------------
   // Owner selection: forced AXI > pixel > pending write > pending read.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: default assignment first so every path drives w_owner; a missing
      // branch would otherwise infer a latch.
      w_owner = OwnIdle;
      if (w_forced) begin
         w_owner = r_wr_pend ? OwnWr : OwnRd;
      end else if (pix_req_i) begin
         w_owner = OwnPix;
      end else if (r_wr_pend) begin
         w_owner = OwnWr;
      end else if (r_rd_pend) begin
         w_owner = OwnRd;
      end
   end

   // A strobe is dropped only if its slot stays occupied across this edge.
   // A slot granted this cycle frees up, so a same-cycle strobe is accepted.
   assign w_wr_drop = axil_write_en_i && r_wr_pend && (w_owner != OwnWr);
   assign w_rd_drop = axil_read_en_i  && r_rd_pend && (w_owner != OwnRd);

   // ---------------------------------------------------------------------------
   // RAM port and pixel-side outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      unique case (w_owner)
         OwnPix: begin
            mem_en_o   = 1'b1;
            mem_addr_o = pix_addr_i;
         end
         OwnWr: begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = r_wr_addr;
            mem_wdata_o = r_wr_data;
         end
         OwnRd: begin
            mem_en_o   = 1'b1;
            mem_addr_o = r_rd_addr;
         end
         default: begin
            mem_en_o = 1'b0;
         end
      endcase
   end

   assign pix_gnt_o       = (w_owner == OwnPix);
   assign pix_rdata_o     = mem_rdata_i;
   assign pix_rvalid_o    = (r_tag == StPix);

   assign axil_rdata_o    = r_axil_rdata;
   assign axil_rvalid_o   = r_axil_rvalid;
   assign axil_busy_o     = w_any_pend;
   assign axil_overflow_o = r_overflow;

   // ---------------------------------------------------------------------------
   // Pending write slot
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!arst_n) begin
         r_wr_pend <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else if (axil_write_en_i && !w_wr_drop) begin
         // Set wins over a same-edge clear from the grant.
         r_wr_pend <= 1'b1;
         r_wr_addr <= axil_addr_write_i;
         r_wr_data <= axil_data_i;
      end else if (w_owner == OwnWr) begin
         r_wr_pend <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Pending read slot
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_rd_pend <= 1'b0;
         r_rd_addr <= '0;
      end else if (axil_read_en_i && !w_rd_drop) begin
         r_rd_pend <= 1'b1;
         r_rd_addr <= axil_addr_read_i;
      end else if (w_owner == OwnRd) begin
         r_rd_pend <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Sticky overflow flag, cleared only by reset
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_overflow <= 1'b0;
      end else if (w_wr_drop || w_rd_drop) begin
         r_overflow <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Bounded-wait counter: counts cycles in which a pending AXI request lost
   // to the pixel fetcher. Any AXI grant restarts the count, so the second of
   // two pending requests waits a fresh MAX_WAIT window.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_wait_cnt <= '0;
      end else if (!w_any_pend || w_owner == OwnWr || w_owner == OwnRd) begin
         r_wait_cnt <= '0;
      end else if (w_owner == OwnPix && r_wait_cnt != MAX_WAIT_C) begin
         r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Read return routing. The tag remembers who issued last cycle's read so
   // mem_rdata_i can be steered to the right consumer when it arrives.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_tag         <= StNone;
         r_axil_rdata  <= '0;
         r_axil_rvalid <= 1'b0;
      end else begin
         unique case (w_owner)
            OwnPix:  r_tag <= StPix;
            OwnRd:   r_tag <= StAxr;
            default: r_tag <= StNone;
         endcase

         r_axil_rvalid <= (r_tag == StAxr);
         if (r_tag == StAxr) begin
            r_axil_rdata <= mem_rdata_i;
         end
      end
   end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_mem_arbiter
//
// Directed bench for vga_mem_arbiter with MAX_WAIT=8. A small behavioural RAM
// (one-cycle read latency) sits on the memory port. Inputs are driven 1 ns
// after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_vga_mem_arbiter;

   localparam int ADDR_W   = 16;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 8;

   logic              clk;
   logic              arst_n;
   logic              axil_write_en_i;
   logic [ADDR_W-1:0] axil_addr_write_i;
   logic [DATA_W-1:0] axil_data_i;
   logic              axil_read_en_i;
   logic [ADDR_W-1:0] axil_addr_read_i;
   logic [DATA_W-1:0] axil_rdata_o;
   logic              axil_rvalid_o;
   logic              axil_busy_o;
   logic              axil_overflow_o;
   logic              pix_req_i;
   logic [ADDR_W-1:0] pix_addr_i;
   logic              pix_gnt_o;
   logic [DATA_W-1:0] pix_rdata_o;
   logic              pix_rvalid_o;
   logic              mem_en_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;

   int n_checks = 0;
   int n_fail   = 0;

   vga_mem_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk               (clk),
      .arst_n            (arst_n),
      .axil_write_en_i   (axil_write_en_i),
      .axil_addr_write_i (axil_addr_write_i),
      .axil_data_i       (axil_data_i),
      .axil_read_en_i    (axil_read_en_i),
      .axil_addr_read_i  (axil_addr_read_i),
      .axil_rdata_o      (axil_rdata_o),
      .axil_rvalid_o     (axil_rvalid_o),
      .axil_busy_o       (axil_busy_o),
      .axil_overflow_o   (axil_overflow_o),
      .pix_req_i         (pix_req_i),
      .pix_addr_i        (pix_addr_i),
      .pix_gnt_o         (pix_gnt_o),
      .pix_rdata_o       (pix_rdata_o),
      .pix_rvalid_o      (pix_rvalid_o),
      .mem_en_o          (mem_en_o),
      .mem_we_o          (mem_we_o),
      .mem_addr_o        (mem_addr_o),
      .mem_wdata_o       (mem_wdata_o),
      .mem_rdata_i       (mem_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural framebuffer RAM, 256 words, read data one cycle after command.
   logic [DATA_W-1:0] ram [0:255];

   always @(posedge clk) begin
      if (mem_en_o) begin
         if (mem_we_o) ram[mem_addr_o[7:0]] <= mem_wdata_o;
         else          mem_rdata_i          <= ram[mem_addr_o[7:0]];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Start the next cycle: wait for the edge, then clear the one-cycle strobes.
   task automatic next_cycle();
      @(posedge clk);
      #1;
      axil_write_en_i = 1'b0;
      axil_read_en_i  = 1'b0;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   int pix_cnt;
   int pulse_cnt;
   int pulse_at;
   logic [DATA_W-1:0] pulse_data;

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = '0;
      ram[8'h10]        = 32'hA5A5_0010;
      ram[8'h30]        = 32'hCAFE_0030;
      ram[8'h31]        = 32'hBAD0_0031;
      mem_rdata_i       = '0;
      arst_n            = 1'b0;
      axil_write_en_i   = 1'b0;
      axil_addr_write_i = '0;
      axil_data_i       = '0;
      axil_read_en_i    = 1'b0;
      axil_addr_read_i  = '0;
      pix_req_i         = 1'b0;
      pix_addr_i        = '0;

      // ---------------- Reset values ----------------
      repeat (2) next_cycle();
      sample();
      check("rst_rdata",    axil_rdata_o,    0);
      check("rst_rvalid",   axil_rvalid_o,   0);
      check("rst_busy",     axil_busy_o,     0);
      check("rst_overflow", axil_overflow_o, 0);
      check("rst_pix_rv",   pix_rvalid_o,    0);
      check("rst_mem_en",   mem_en_o,        0);
      check("rst_pix_gnt",  pix_gnt_o,       0);
      next_cycle();
      arst_n = 1'b1;

      // ---------------- Single pixel fetch ----------------
      next_cycle();
      pix_req_i  = 1'b1;
      pix_addr_i = 16'h0010;
      sample();
      check("pix_gnt",      pix_gnt_o,  1);
      check("pix_mem_en",   mem_en_o,   1);
      check("pix_mem_we",   mem_we_o,   0);
      check("pix_mem_addr", mem_addr_o, 16'h0010);
      check("pix_rv_early", pix_rvalid_o, 0);
      next_cycle();
      pix_req_i = 1'b0;
      sample();
      check("pix_rvalid", pix_rvalid_o, 1);
      check("pix_rdata",  pix_rdata_o,  32'hA5A5_0010);
      check("pix_gnt_off", pix_gnt_o,   0);
      next_cycle();
      sample();
      check("pix_rv_once", pix_rvalid_o, 0);

      // ---------------- Write then read, idle memory ----------------
      next_cycle();                                   // T
      axil_write_en_i   = 1'b1;
      axil_addr_write_i = 16'h0004;
      axil_data_i       = 32'hDEAD_BEEF;
      sample();
      check("wr_T_mem_en", mem_en_o, 0);
      next_cycle();                                   // T+1
      sample();
      check("wr_T1_we",    mem_we_o,    1);
      check("wr_T1_addr",  mem_addr_o,  16'h0004);
      check("wr_T1_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      check("wr_T1_busy",  axil_busy_o, 1);
      next_cycle();                                   // T+2
      axil_read_en_i   = 1'b1;
      axil_addr_read_i = 16'h0004;
      sample();
      check("rd_T2_busy",  axil_busy_o, 0);
      check("rd_T2_en",    mem_en_o,    0);
      next_cycle();                                   // T+3
      sample();
      check("rd_T3_en",    mem_en_o,   1);
      check("rd_T3_we",    mem_we_o,   0);
      check("rd_T3_addr",  mem_addr_o, 16'h0004);
      next_cycle();                                   // T+4
      sample();
      check("rd_T4_rvalid", axil_rvalid_o, 0);
      check("rd_T4_pix_rv", pix_rvalid_o,  0);
      next_cycle();                                   // T+5
      sample();
      check("rd_T5_rvalid", axil_rvalid_o, 1);
      check("rd_T5_rdata",  axil_rdata_o,  32'hDEAD_BEEF);
      next_cycle();                                   // T+6
      sample();
      check("rd_T6_rvalid", axil_rvalid_o, 0);
      check("rd_T6_hold",   axil_rdata_o,  32'hDEAD_BEEF);

      // ---------------- Same-cycle write and read, same address ----------------
      next_cycle();                                   // T
      axil_write_en_i   = 1'b1;
      axil_addr_write_i = 16'h0020;
      axil_data_i       = 32'h1234_5678;
      axil_read_en_i    = 1'b1;
      axil_addr_read_i  = 16'h0020;
      next_cycle();                                   // T+1
      sample();
      check("wr_rd_T1_we",   mem_we_o,   1);
      check("wr_rd_T1_addr", mem_addr_o, 16'h0020);
      next_cycle();                                   // T+2
      sample();
      check("wr_rd_T2_en",   mem_en_o,   1);
      check("wr_rd_T2_we",   mem_we_o,   0);
      check("wr_rd_T2_addr", mem_addr_o, 16'h0020);
      next_cycle();                                   // T+3
      sample();
      check("wr_rd_T3_rv",   axil_rvalid_o, 0);
      next_cycle();                                   // T+4
      sample();
      check("wr_rd_T4_rv",    axil_rvalid_o, 1);
      check("wr_rd_T4_rdata", axil_rdata_o,  32'h1234_5678);

      // ---------------- Forced write under continuous pixel load ----------------
      next_cycle();                                   // T
      pix_req_i         = 1'b1;
      pix_addr_i        = 16'h0040;
      axil_write_en_i   = 1'b1;
      axil_addr_write_i = 16'h0008;
      axil_data_i       = 32'h0000_0055;
      sample();
      check("force_T_gnt", pix_gnt_o, 1);
      pix_cnt = 0;
      for (int i = 1; i <= MAX_WAIT; i++) begin       // T+1 .. T+8
         next_cycle();
         sample();
         if (pix_gnt_o === 1'b1) pix_cnt++;
      end
      check("force_denied_cycles", pix_cnt, MAX_WAIT);
      next_cycle();                                   // T+9
      sample();
      check("force_gnt_low", pix_gnt_o,  0);
      check("force_we",      mem_we_o,   1);
      check("force_addr",    mem_addr_o, 16'h0008);
      check("force_pix_rv",  pix_rvalid_o, 1);
      next_cycle();                                   // T+10
      sample();
      check("force_resume",  pix_gnt_o,    1);
      check("force_no_pixrv", pix_rvalid_o, 0);
      check("force_busy",    axil_busy_o,  0);

      // ---------------- Read overflow under pixel load ----------------
      next_cycle();                                   // T (pix_req still high)
      axil_read_en_i   = 1'b1;
      axil_addr_read_i = 16'h0030;
      sample();
      check("ovf_T_flag", axil_overflow_o, 0);
      next_cycle();                                   // T+1
      next_cycle();                                   // T+2
      axil_read_en_i   = 1'b1;
      axil_addr_read_i = 16'h0031;
      next_cycle();                                   // T+3
      sample();
      check("ovf_T3_flag", axil_overflow_o, 1);
      pulse_cnt  = 0;
      pulse_at   = -1;
      pulse_data = '0;
      for (int c = 4; c <= 20; c++) begin             // T+4 .. T+20
         next_cycle();
         if (c == 12) pix_req_i = 1'b0;
         sample();
         if (c == 9) check("ovf_T9_gnt_low", pix_gnt_o, 0);
         if (axil_rvalid_o === 1'b1) begin
            pulse_cnt++;
            pulse_at   = c;
            pulse_data = axil_rdata_o;
         end
      end
      check("ovf_pulse_cnt",  pulse_cnt,  1);
      check("ovf_pulse_at",   pulse_at,   11);
      check("ovf_rdata",      pulse_data, 32'hCAFE_0030);
      check("ovf_sticky",     axil_overflow_o, 1);
      check("ovf_busy_done",  axil_busy_o, 0);

      // ---------------- Reset while a read is in flight ----------------
      next_cycle();                                   // T
      axil_read_en_i   = 1'b1;
      axil_addr_read_i = 16'h0004;
      next_cycle();                                   // T+1
      sample();
      check("rrst_T1_rd_issued", mem_en_o & ~mem_we_o, 1);
      next_cycle();                                   // T+2
      arst_n = 1'b0;
      sample();
      check("rrst_busy_in_rst", axil_busy_o, 0);
      next_cycle();
      arst_n = 1'b1;
      pulse_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         sample();
         if (axil_rvalid_o === 1'b1) pulse_cnt++;
         next_cycle();
      end
      check("rrst_no_rvalid", pulse_cnt,       0);
      check("rrst_busy",      axil_busy_o,     0);
      check("rrst_overflow",  axil_overflow_o, 0);
      check("rrst_rdata",     axil_rdata_o,    0);

      // ---------------- Strobe on the grant cycle is accepted ----------------
      axil_write_en_i   = 1'b1;                       // T
      axil_addr_write_i = 16'h0050;
      axil_data_i       = 32'h0000_0001;
      next_cycle();                                   // T+1: first write granted
      axil_write_en_i   = 1'b1;
      axil_addr_write_i = 16'h0051;
      axil_data_i       = 32'h0000_0002;
      sample();
      check("regrant_T1_addr", mem_addr_o, 16'h0050);
      next_cycle();                                   // T+2
      sample();
      check("regrant_T2_we",    mem_we_o,        1);
      check("regrant_T2_addr",  mem_addr_o,      16'h0051);
      check("regrant_T2_wdata", mem_wdata_o,     32'h0000_0002);
      check("regrant_no_ovf",   axil_overflow_o, 0);
      next_cycle();
      sample();
      check("regrant_idle", mem_en_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Single-port framebuffer memory arbiter between the VGA pixel fetcher and the AXI-Lite slave FSM. Accepts one-cycle write/read strobes from the AXI-Lite side, holds them as pending requests, and schedules them around real-time pixel fetches. A bounded-wait counter prevents AXI starvation. Sits between `axil_slave_fsm` outputs, the scanout pixel fetch logic, and the framebuffer RAM.

## Interface
- ADDR_W, 16, word address width (matches `axil_addr_t` low bits used for framebuffer).
- DATA_W, 32, data width (matches `axil_data_t`).
- MAX_WAIT, 8, max cycles an AXI pending request may be denied before forced grant; legal range 1..255.

- clk  in  1  clock; all logic on posedge.
- arst_n  in  1  asynchronous active-low reset.
- axil_write_en_i  in  1  one-cycle write strobe from slave FSM.
- axil_addr_write_i  in  ADDR_W  write address, sampled with strobe.
- axil_data_i  in  DATA_W  write data, sampled with strobe.
- axil_read_en_i  in  1  one-cycle read strobe.
- axil_addr_read_i  in  ADDR_W  read address, sampled with strobe.
- axil_rdata_o  out  DATA_W  registered read data, held until next AXI read returns.
- axil_rvalid_o  out  1  one-cycle pulse, axil_rdata_o valid.
- axil_busy_o  out  1  any AXI request pending.
- axil_overflow_o  out  1  sticky: strobe arrived while same-kind request pending.
- pix_req_i  in  1  pixel fetch request (level).
- pix_addr_i  in  ADDR_W  pixel fetch address.
- pix_gnt_o  out  1  combinational grant to pixel fetcher this cycle.
- pix_rdata_o  out  DATA_W  pass-through of mem_rdata_i.
- pix_rvalid_o  out  1  pixel data valid (cycle after pix_gnt_o).
- mem_en_o, mem_we_o  out  1  RAM enable / write enable (combinational).
- mem_addr_o  out  ADDR_W; mem_wdata_o  out  DATA_W.
- mem_rdata_i  in  DATA_W  RAM read data, valid 1 cycle after read command.

## Operation
- Pending registers: wr_pend (addr, data), rd_pend (addr). Set on strobe edge; cleared at edge of the cycle they are granted. Strobe while same-kind pending: dropped, axil_overflow_o set; original pending kept.
- Strobe in same cycle the pending of that kind is granted: accepted (clear and set same edge → set wins).
- Owner per cycle (combinational), priority:
  - wait_cnt == MAX_WAIT and any AXI pending: AXI forced (write before read).
  - else pix_req_i: pixel.
  - else wr_pend: write; else rd_pend: read; else idle (mem_en_o=0).
- wait_cnt: increments when AXI pending and owner is pixel; reset to 0 on any AXI grant or when no AXI pending; saturates at MAX_WAIT.
- Registered return tag (StNone, StPix, StAxr) records the read owner of previous cycle; routes mem_rdata_i: StPix → pix_rvalid_o=1; StAxr → capture into axil_rdata_o, axil_rvalid_o=1 next cycle.
- Write and read pending same address: write granted first, so read returns new data.
- axil_busy_o = wr_pend | rd_pend.

## Timing
- Reset values: all pending cleared, wait_cnt=0, tag=StNone, axil_rdata_o=0, axil_rvalid_o=0, axil_overflow_o=0; hence pix_rvalid_o=0, axil_busy_o=0; mem_en_o=pix_gnt_o only from live pix_req_i.
- Reset mid-operation: pendings and in-flight returns discarded; no rvalid pulse after reset release.
- AXI write, idle memory: strobe cycle T → mem write in T+1.
- AXI read, idle memory: strobe T → mem read T+1 → mem_rdata_i T+2 → axil_rvalid_o T+3.
- Pixel: pix_gnt_o in cycle G → pix_rvalid_o in G+1. Pixel fetcher must hold pix_req_i/pix_addr_i until granted.
- Continuous pix_req_i with AXI pending: AXI granted after exactly MAX_WAIT denied cycles; pix_gnt_o low that cycle.
- Both AXI pending under forced grant: write forced first; read waits anew (counter reset), served next free or after another MAX_WAIT cycles.
- Slave FSM must not rely on fixed read latency; it waits for axil_rvalid_o.

## Test plan
- Reset → all outputs at reset values; pix_req_i=1, pix_addr_i=0x10 → pix_gnt_o=1, mem_addr_o=0x10, pix_rvalid_o next cycle.
- Write 0xDEADBEEF to 0x0004 at T, read 0x0004 at T+2, no pixel traffic → mem write at T+1, axil_rvalid_o at T+5 with axil_rdata_o=0xDEADBEEF.
- pix_req_i held high, AXI write strobe, MAX_WAIT=8 → 8 pixel grants, write on 9th cycle, pix_gnt_o=0 that cycle, then pixel resumes.
- Write and read strobes same cycle, both addr 0x0020, data 0x12345678, old contents 0 → write T+1, read T+2, axil_rdata_o=0x12345678.
- Second read strobe while rd_pend under pixel load → axil_overflow_o=1 sticky, only one axil_rvalid_o pulse, first address returned.
- Assert arst_n=0 the cycle after an AXI read is issued to RAM → no axil_rvalid_o after release, axil_busy_o=0.
